// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants, duty type and fade-step helper
// for the LED PWM fader (channel layout R0-3, G0-3, B0-3).
package led_pwm_pkg;

  localparam int NUM_LEDS   = 4;
  localparam int CH_PER_LED = 3;
  localparam int NUM_CH     = NUM_LEDS * CH_PER_LED;
  localparam int CH_R_BASE  = 0;
  localparam int CH_G_BASE  = 4;
  localparam int CH_B_BASE  = 8;

  typedef logic [7:0] duty_t;

  // One ramp step toward target, clamped so it never overshoots.
  // step == 0 snaps straight to target.
  function automatic duty_t fade_next(
    input duty_t duty,
    input duty_t target,
    input duty_t step
  );
    logic [8:0]        up;
    logic signed [9:0] dn;
    duty_t             res;
    up  = {1'b0, duty} + {1'b0, step};
    dn  = $signed({2'b00, duty}) - $signed({2'b00, step});
    res = target;
    if (step != '0 && duty < target) begin
      if (up < {1'b0, target}) res = up[7:0];
    end else if (step != '0 && duty > target) begin
      if (dn > $signed({2'b00, target})) res = dn[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// led_fade_channel: one PWM channel (duty ramp, brightness latch, compare).
// Ports: clk, resetn, boundary, target, brightness, pwm_cnt, enable -> led.
module led_fade_channel
  import led_pwm_pkg::*;
#(
  parameter int FADE_STEP = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       boundary,
  input  duty_t      target,
  input  logic [7:0] brightness,
  input  logic [7:0] pwm_cnt,
  input  logic       enable,
  output logic       led
);

  localparam duty_t STEP = duty_t'(FADE_STEP);

  duty_t       duty;
  duty_t       eff;
  duty_t       duty_nxt;
  logic [16:0] prod;

  always_comb begin
    duty_nxt = fade_next(duty, target, STEP);
    prod     = {9'b0, duty_nxt} * ({9'b0, brightness} + 17'd1);
  end

  // eff only moves at the period boundary, so the PWM
  // waveform never changes shape mid-period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty <= '0;
      eff  <= '0;
      led  <= 1'b0;
    end else begin
      if (boundary) begin
        duty <= duty_nxt;
        eff  <= duty_t'(prod >> 8);
      end
      led <= enable && (pwm_cnt < eff);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: 12-pin PWM LED driver with brightness and fade ramps.
// Ports: clk, resetn, led_in[8], brightness[8], enable -> led_out[12], period_start.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int ON_LEVEL  = 255,
  parameter int FADE_STEP = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        led_in,
  input  logic [7:0]        brightness,
  input  logic              enable,
  output logic [NUM_CH-1:0] led_out,
  output logic              period_start
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam duty_t       ON      = duty_t'(ON_LEVEL);

  logic [15:0]       presc;
  logic [7:0]        pwm_cnt;
  logic              tick;
  logic              boundary;
  logic [NUM_CH-1:0] on;

  assign tick     = (presc == PS_LAST);
  assign boundary = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 16'd1;
      period_start <= boundary;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Blue is lit only when both request bits of an LED are set.
  always_comb begin
    on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      on[CH_R_BASE+i] = led_in[2*i];
      on[CH_G_BASE+i] = led_in[2*i+1];
      on[CH_B_BASE+i] = led_in[2*i] & led_in[2*i+1];
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    led_fade_channel #(
      .FADE_STEP(FADE_STEP)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .boundary  (boundary),
      .target    (on[ch] ? ON : duty_t'(0)),
      .brightness(brightness),
      .pwm_cnt   (pwm_cnt),
      .enable    (enable),
      .led       (led_out[ch])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: period-level high-count checks of led_pwm_fader
// (ramp DUT with FADE_STEP 16, snap DUT with FADE_STEP 0).
module tb_led_pwm_fader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  led_in = '0;
  logic [7:0]  bri = '0;
  logic        en = 1'b0;
  logic [11:0] out_a, out_b;
  logic        ps_a, ps_b;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .PRESCALE(1), .ON_LEVEL(255), .FADE_STEP(16)
  ) u_a (
    .clk(clk), .resetn(resetn), .led_in(led_in),
    .brightness(bri), .enable(en),
    .led_out(out_a), .period_start(ps_a)
  );

  led_pwm_fader #(
    .PRESCALE(1), .ON_LEVEL(255), .FADE_STEP(0)
  ) u_b (
    .clk(clk), .resetn(resetn), .led_in(led_in),
    .brightness(bri), .enable(en),
    .led_out(out_b), .period_start(ps_b)
  );

  typedef logic [11:0][7:0] exp_t;
  typedef struct {
    logic [7:0] li;
    logic [7:0] r0;
  } vec_a_t;
  typedef struct {
    logic [7:0] li;
    logic [7:0] br;
    logic [7:0] mid;
    logic [7:0] von;
  } vec_b_t;

  vec_a_t ta[37];
  vec_b_t tb[8];
  exp_t   q[$];
  int     cnt[12];
  int     nvec = 0;
  int     nmis = 0;

  function automatic exp_t exp_a(input vec_a_t v);
    exp_t e;
    e = '0;
    e[0] = v.r0;
    return e;
  endfunction

  function automatic exp_t exp_b(input vec_b_t v);
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e[i]   = v.li[2*i] ? v.von : 8'd0;
      e[4+i] = v.li[2*i+1] ? v.von : 8'd0;
      e[8+i] = (v.li[2*i] && v.li[2*i+1]) ? v.von : 8'd0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int want);
    nvec++;
    if (act != want) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic wait_ps(input bit sel);
    int n;
    n = 0;
    while (!(sel ? ps_b : ps_a) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      nvec++;
      nmis++;
      $display("FAIL period_start timeout: got none in %0d cycles, want pulse", n);
    end
  endtask

  // Waits for a period start, applies new inputs there, then counts
  // high samples per channel over the 256 cycles of that period.
  task automatic run_period(
    input bit sel, input logic [7:0] li, input logic [7:0] br,
    input int mid_at, input logic [7:0] mid_bri, input int en_at
  );
    logic [11:0] o;
    wait_ps(sel);
    led_in = li;
    bri    = br;
    for (int ch = 0; ch < 12; ch++) cnt[ch] = 0;
    for (int i = 0; i < 256; i++) begin
      o = sel ? out_b : out_a;
      for (int ch = 0; ch < 12; ch++) cnt[ch] += int'(o[ch]);
      if (i == mid_at) bri = mid_bri;
      if (i == en_at) en = 1'b0;
      if (en_at >= 0 && i == en_at + 10) en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic compare_period(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      nvec++;
      nmis++;
      $display("FAIL %s: got empty scoreboard, want entry", tag);
    end else begin
      e = q.pop_front();
      for (int ch = 0; ch < 12; ch++)
        check($sformatf("%s ch%0d", tag, ch), cnt[ch], int'(e[ch]));
    end
  endtask

  initial begin
    exp_t ee;
    int   n;

    for (int k = 0; k < 18; k++)
      ta[k] = '{li: 8'h01, r0: (k < 15) ? 8'(16 * (k + 1)) : 8'd255};
    for (int j = 1; j <= 9; j++)
      ta[17+j] = '{li: 8'h00, r0: 8'(255 - 16 * j)};
    ta[27] = '{li: 8'h01, r0: 8'd127};
    for (int m = 0; m < 9; m++)
      ta[28+m] = '{li: 8'h00, r0: (m < 7) ? 8'(111 - 16 * m) : 8'd0};

    tb[0] = '{li: 8'h03, br: 8'd255, mid: 8'd255, von: 8'd255};
    tb[1] = '{li: 8'h03, br: 8'd127, mid: 8'd127, von: 8'd127};
    tb[2] = '{li: 8'h03, br: 8'd127, mid: 8'd255, von: 8'd255};
    tb[3] = '{li: 8'hFF, br: 8'd63,  mid: 8'd63,  von: 8'd63};
    tb[4] = '{li: 8'h5A, br: 8'd255, mid: 8'd255, von: 8'd255};
    tb[5] = '{li: 8'h0C, br: 8'd0,   mid: 8'd0,   von: 8'd0};
    tb[6] = '{li: 8'hC3, br: 8'd1,   mid: 8'd1,   von: 8'd1};
    tb[7] = '{li: 8'h03, br: 8'd255, mid: 8'd255, von: 8'd255};

    // Reset state.
    led_in = ta[0].li;
    bri    = 8'd255;
    en     = 1'b1;
    #1;
    check("reset led_out a", int'(out_a), 0);
    check("reset led_out b", int'(out_b), 0);
    check("reset period_start a", int'(ps_a), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Ramp up, ramp down, re-assert mid-ramp, ramp to zero.
    q.push_back(exp_a(ta[0]));
    for (int k = 1; k < 37; k++) begin
      run_period(1'b0, ta[k].li, 8'd255, -1, 8'd255, -1);
      q.push_back(exp_a(ta[k]));
      compare_period($sformatf("fade vec%0d", k - 1));
    end
    run_period(1'b0, ta[36].li, 8'd255, -1, 8'd255, -1);
    compare_period("fade vec36");

    // Snap DUT: brightness scaling, colour decode, mid-period bri change.
    @(negedge clk);
    resetn = 1'b0;
    led_in = tb[0].li;
    bri    = tb[0].br;
    @(negedge clk);
    resetn = 1'b1;
    q.push_back(exp_b(tb[0]));
    for (int k = 1; k < 8; k++) begin
      run_period(1'b1, tb[k].li, tb[k].br, 128, tb[k].mid, -1);
      q.push_back(exp_b(tb[k]));
      compare_period($sformatf("bri vec%0d", k - 1));
    end
    run_period(1'b1, tb[7].li, tb[7].br, -1, 8'd255, -1);
    compare_period("bri vec7");

    // enable low for 10 cycles mid-period drops exactly 10 high slots.
    ee = '0;
    ee[0] = 8'd245;
    ee[4] = 8'd245;
    ee[8] = 8'd245;
    q.push_back(ee);
    run_period(1'b1, 8'h03, 8'd255, -1, 8'd255, 100);
    compare_period("enable gap");
    check("enable phase period_start", int'(ps_b), 1);

    // Asynchronous reset at pwm_cnt 100.
    wait_ps(1'b1);
    repeat (100) @(negedge clk);
    check("pre-reset led_out", int'(out_b), 'h111);
    #1;
    resetn = 1'b0;
    #1;
    check("async reset led_out", int'(out_b), 0);
    check("async reset period_start", int'(ps_b), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps_b && n < 600);
    check("first period_start after reset", n, 256);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
